laser_feeder: RTL and testbench

LASER_FEEDER -- requirements
Module: laser_feeder

---
 rtl/laser_feeder.sv | 173 +++++++++++++++++
 tb/tb_laser_feeder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/laser_feeder.sv
// Point-RAM feeder and coverage scorer wrapped around an external laser core.
// Optional wait watchdog is enabled by defining LASER_FEEDER_TIMEOUT_EN.
module laser_feeder (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       LD_EN,
    input  logic [5:0] LD_ADDR,
    input  logic [3:0] LD_X,
    input  logic [3:0] LD_Y,
    output logic       LRST,
    output logic [3:0] X,
    output logic [3:0] Y,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    input  logic       DONE,
    output logic       BUSY,
    output logic       RES_VALID,
    output logic [5:0] COVER,
    output logic [3:0] R1X,
    output logic [3:0] R1Y,
    output logic [3:0] R2X,
    output logic [3:0] R2Y,
    output logic       TIMEOUT
);

    typedef enum logic [2:0] {
        IDLE, RSTP, SEND, WAIT, CAPT, SCORE, REPORT
    } state_t;

    state_t     state;
    logic [5:0] idx;
    logic [5:0] acc;
    logic [5:0] rd_addr;
    logic [7:0] pt;
    logic       hit;
    logic [7:0] ram [40];

`ifdef LASER_FEEDER_TIMEOUT_EN
    logic [15:0] wdog;
`endif

    function automatic logic in_circle(input logic [7:0] p,
                                       input logic [3:0] cx,
                                       input logic [3:0] cy);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [8:0] d;
        dx = (p[7:4] >= cx) ? p[7:4] - cx : cx - p[7:4];
        dy = (p[3:0] >= cy) ? p[3:0] - cy : cy - p[3:0];
        d  = 9'(dx) * 9'(dx) + 9'(dy) * 9'(dy);
        return d <= 9'd16;
    endfunction

    // SEND looks one entry ahead so X/Y are registered in step with k
    always_comb begin
        rd_addr = idx;
        if (state == SEND && idx != 6'd39)
            rd_addr = idx + 6'd1;
    end

    assign pt   = ram[rd_addr];
    assign hit  = in_circle(pt, R1X, R1Y) | in_circle(pt, R2X, R2Y);
    assign BUSY = (state != IDLE);

    // Point RAM is deliberately outside the reset domain
    always_ff @(posedge CLK) begin
        if (LD_EN && state == IDLE && LD_ADDR < 6'd40)
            ram[LD_ADDR] <= {LD_X, LD_Y};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            LRST      <= 1'b0;
            X         <= '0;
            Y         <= '0;
            RES_VALID <= 1'b0;
            COVER     <= '0;
            R1X       <= '0;
            R1Y       <= '0;
            R2X       <= '0;
            R2Y       <= '0;
`ifdef LASER_FEEDER_TIMEOUT_EN
            wdog      <= '0;
            TIMEOUT   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    RES_VALID <= 1'b0;
                    if (START) begin
                        state <= RSTP;
                        LRST  <= 1'b1;
                        idx   <= '0;
`ifdef LASER_FEEDER_TIMEOUT_EN
                        TIMEOUT <= 1'b0;
`endif
                    end
                end
                RSTP: begin
                    LRST  <= 1'b0;
                    X     <= pt[7:4];
                    Y     <= pt[3:0];
                    idx   <= '0;
                    state <= SEND;
                end
                SEND: begin
                    if (idx == 6'd39) begin
                        X     <= '0;
                        Y     <= '0;
                        state <= WAIT;
`ifdef LASER_FEEDER_TIMEOUT_EN
                        wdog  <= '0;
`endif
                    end else begin
                        idx <= idx + 6'd1;
                        X   <= pt[7:4];
                        Y   <= pt[3:0];
                    end
                end
                WAIT: begin
                    if (DONE) begin
                        R1X   <= C1X;
                        R1Y   <= C1Y;
                        R2X   <= C2X;
                        R2Y   <= C2Y;
                        state <= CAPT;
                    end
`ifdef LASER_FEEDER_TIMEOUT_EN
                    else if (wdog == 16'hFFFE) begin
                        TIMEOUT   <= 1'b1;
                        COVER     <= '0;
                        RES_VALID <= 1'b1;
                        state     <= REPORT;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
`endif
                end
                CAPT: begin
                    acc   <= '0;
                    idx   <= '0;
                    state <= SCORE;
                end
                SCORE: begin
                    acc <= acc + 6'(hit);
                    if (idx == 6'd39) begin
                        COVER     <= acc + 6'(hit);
                        RES_VALID <= 1'b1;
                        state     <= REPORT;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                REPORT: begin
                    RES_VALID <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef LASER_FEEDER_TIMEOUT_EN
    assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_laser_feeder.sv
// Directed plus randomized bench for laser_feeder against a
// geometric coverage model of the point set.
module tb_laser_feeder;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic       LD_EN = 1'b0;
    logic [5:0] LD_ADDR = '0;
    logic [3:0] LD_X = '0;
    logic [3:0] LD_Y = '0;
    logic [3:0] C1X = '0;
    logic [3:0] C1Y = '0;
    logic [3:0] C2X = '0;
    logic [3:0] C2Y = '0;
    logic       DONE = 1'b0;
    logic       LRST;
    logic [3:0] X;
    logic [3:0] Y;
    logic       BUSY;
    logic       RES_VALID;
    logic [5:0] COVER;
    logic [3:0] R1X;
    logic [3:0] R1Y;
    logic [3:0] R2X;
    logic [3:0] R2Y;
    logic       TIMEOUT;

    laser_feeder dut (
        .CLK(CLK), .RST_N(RST_N), .START(START),
        .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_X(LD_X), .LD_Y(LD_Y),
        .LRST(LRST), .X(X), .Y(Y),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .DONE(DONE), .BUSY(BUSY), .RES_VALID(RES_VALID),
        .COVER(COVER), .R1X(R1X), .R1Y(R1Y), .R2X(R2X), .R2Y(R2Y),
        .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;
    logic [3:0] mx [40];
    logic [3:0] my [40];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic bit in_c(input int px, input int py,
                                input int cx, input int cy);
        return (px - cx) * (px - cx) + (py - cy) * (py - cy) <= 16;
    endfunction

    function automatic int model_cover(input int ax, input int ay,
                                       input int bx, input int by);
        int n = 0;
        for (int i = 0; i < 40; i++)
            if (in_c(mx[i], my[i], ax, ay) || in_c(mx[i], my[i], bx, by))
                n++;
        return n;
    endfunction

    task automatic load_ram();
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            LD_EN = 1'b1; LD_ADDR = 6'(i); LD_X = mx[i]; LD_Y = my[i];
        end
        @(negedge CLK);
        LD_ADDR = 6'd40; LD_X = 4'hA; LD_Y = 4'h5;
        @(negedge CLK);
        LD_ADDR = 6'd63;
        @(negedge CLK);
        LD_EN = 1'b0;
    endtask

    task automatic run_job(input logic [3:0] ax, input logic [3:0] ay,
                           input logic [3:0] bx, input logic [3:0] by,
                           input int w);
        int t;
        int exp;
        exp = model_cover(ax, ay, bx, by);
        @(negedge CLK); START = 1'b1; t = 0;
        @(negedge CLK); START = 1'b0; t = 1;
        check("rstp_lrst", LRST, 1);
        check("rstp_busy", BUSY, 1);
        check("start_clears_timeout", TIMEOUT, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK); t++;
            START = 1'b0; DONE = 1'b0; LD_EN = 1'b0;
            check("stream_x", X, mx[k]);
            check("stream_y", Y, my[k]);
            check("stream_lrst", LRST, 0);
            if (k == 10) START = 1'b1;
            if (k == 20) begin
                DONE = 1'b1; C1X = 4'd7; C1Y = 4'd7; C2X = 4'd9; C2Y = 4'd1;
            end
            if (k == 30) begin
                LD_EN = 1'b1; LD_ADDR = 6'd39;
                LD_X = ~mx[39]; LD_Y = ~my[39];
            end
        end
        for (int i = 1; i <= w; i++) begin
            @(negedge CLK); t++;
            START = 1'b0; DONE = 1'b0; LD_EN = 1'b0;
            check("wait_x", X, 0);
            check("wait_busy", BUSY, 1);
            check("wait_no_result", RES_VALID, 0);
            if (i == w) begin
                DONE = 1'b1; C1X = ax; C1Y = ay; C2X = bx; C2Y = by;
            end
        end
        @(negedge CLK); t++;
        DONE = 1'b0; C1X = ~ax; C1Y = ~ay; C2X = ~bx; C2Y = ~by;
        check("capt_r1x", R1X, ax);
        check("capt_r1y", R1Y, ay);
        check("capt_r2x", R2X, bx);
        check("capt_r2y", R2Y, by);
        while (RES_VALID !== 1'b1 && t < 200) begin
            @(negedge CLK); t++;
        end
        check("latency", t, 83 + w);
        check("cover", COVER, exp);
        check("report_timeout", TIMEOUT, 0);
        @(negedge CLK);
        check("valid_one_pulse", RES_VALID, 0);
        check("idle_busy", BUSY, 0);
        check("cover_hold", COVER, exp);
        check("r2y_hold", R2Y, by);
    endtask

    initial begin
        int t;
        @(negedge CLK);
        check("rst_busy", BUSY, 0);
        check("rst_lrst", LRST, 0);
        check("rst_xy", {X, Y}, 0);
        check("rst_valid", RES_VALID, 0);
        check("rst_cover", COVER, 0);
        check("rst_r", {R1X, R1Y, R2X, R2Y}, 0);
        check("rst_timeout", TIMEOUT, 0);
        @(negedge CLK); RST_N = 1'b1;

        for (int i = 0; i < 40; i++) begin mx[i] = 5; my[i] = 5; end
        load_ram();
        run_job(4'd5, 4'd5, 4'd0, 4'd0, 3);
        check("all_in_c1", COVER, 40);

        for (int i = 0; i < 40; i++) begin
            mx[i] = (i < 20) ? 4'd2 : 4'd12;
            my[i] = mx[i];
        end
        load_ram();
        run_job(4'd2, 4'd2, 4'd12, 4'd12, 1);
        check("two_clusters", COVER, 40);
        run_job(4'd2, 4'd2, 4'd2, 4'd2, 2);
        check("no_double_count", COVER, 20);

        for (int i = 0; i < 40; i++) begin mx[i] = 15; my[i] = 15; end
        mx[0] = 0; my[0] = 4; mx[1] = 4; my[1] = 4;
        load_ram();
        run_job(4'd0, 4'd0, 4'd0, 4'd0, 4);
        check("radius_edge", COVER, 1);

        // abort in the middle of scoring, then rerun with RAM intact
        run_job(4'd0, 4'd4, 4'd3, 4'd3, 1);
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        repeat (41) @(negedge CLK);
        DONE = 1'b1; C1X = 4'd1; C1Y = 4'd1; C2X = 4'd2; C2Y = 4'd2;
        @(negedge CLK); DONE = 1'b0;
        repeat (12) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("abort_busy", BUSY, 0);
        check("abort_xy_lrst", {LRST, X, Y}, 0);
        check("abort_valid", RES_VALID, 0);
        check("abort_cover", COVER, 0);
        check("abort_r", {R1X, R1Y, R2X, R2Y}, 0);
        check("abort_timeout", TIMEOUT, 0);
        @(negedge CLK); RST_N = 1'b1;
        run_job(4'd0, 4'd0, 4'd4, 4'd4, 2);

        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 40; i++) begin
                mx[i] = 4'($urandom_range(0, 15));
                my[i] = 4'($urandom_range(0, 15));
            end
            load_ram();
            run_job(mx[j], my[j], 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), int'($urandom_range(1, 6)));
        end

`ifdef LASER_FEEDER_TIMEOUT_EN
        @(negedge CLK); START = 1'b1; t = 0;
        @(negedge CLK); START = 1'b0; t = 1;
        while (RES_VALID !== 1'b1 && t < 70000) begin
            @(negedge CLK); t++;
        end
        check("wd_latency", t, 42 + 65535);
        check("wd_timeout", TIMEOUT, 1);
        check("wd_cover", COVER, 0);
        @(negedge CLK);
        check("wd_one_pulse", RES_VALID, 0);
        check("wd_sticky", TIMEOUT, 1);
        run_job(4'd3, 4'd3, 4'd8, 4'd8, 2);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
